// File: rtl/router_rx_pkg.sv
// Shared types for the router port receive path.
// Byte entries carry an end-of-packet flag alongside the data.
package router_rx_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    SKIP,
    IDLE,
    RECV
  } rx_state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  function automatic logic [DATA_W-1:0] low_mask(
    input logic [2:0] n
  );
    return (8'd1 << n) - 8'd1;
  endfunction

endpackage

// File: rtl/router_port_rx_if.sv
// Byte stream handshake between the receiver and its consumer.
// Head byte is offered with valid; consumer pulls with ready.
interface router_port_rx_if;
  import router_rx_pkg::*;

  logic [DATA_W-1:0] byte_data;
  logic              byte_last;
  logic              byte_valid;
  logic              byte_ready;

  modport master (
    output byte_data,
    output byte_last,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_last,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/router_rx_fifo.sv
// First-word fall-through FIFO of received byte entries.
// A push while full succeeds only if a pop happens on the same edge.
module router_rx_fifo
  import router_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  rx_entry_t push_data,
  input  logic      pop,
  output rx_entry_t pop_data,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  rx_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head view is forced to zero when empty so outputs never show stale data.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_port_rx.sv
// Serial-to-byte receiver for one router output port.
// Define RX_STATS_EN to add packet and byte counters.
module router_port_rx
  import router_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
`ifdef RX_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic SystemClk,
  input  logic reset,
  input  logic dout,
  input  logic valido_n,
  input  logic frameo_n,
  router_port_rx_if.master rx,
  output logic frame_err,
  output logic overflow,
  output logic busy
`ifdef RX_STATS_EN
  , output logic [CNT_W-1:0] pkt_cnt
  , output logic [CNT_W-1:0] byte_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  rx_state_t         state;
  logic [2:0]        idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] cap_byte;
  logic              cap;
  logic              push;
  rx_entry_t         push_e;
  logic              pop;
  rx_entry_t         head;
  logic              full;
  logic              empty;
  logic [AW:0]       count;

  assign cap = ~valido_n;
  assign pop = rx.byte_valid & rx.byte_ready;

  // Bits above idx may be stale from the previous byte, so mask them off.
  assign cap_byte = (shreg & low_mask(idx))
                  | ({7'd0, dout} << idx);

  always_comb begin
    push   = 1'b0;
    push_e = '0;
    if (state == RECV) begin
      if (cap && (idx == 3'd7 || frameo_n)) begin
        push   = 1'b1;
        push_e = '{last: frameo_n, data: cap_byte};
      end else if (!cap && frameo_n && idx != 3'd0) begin
        push   = 1'b1;
        push_e = '{last: 1'b1, data: shreg & low_mask(idx)};
      end
    end
  end

  always_ff @(posedge SystemClk) begin
    if (reset) begin
      state     <= SKIP;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (state)
        SKIP: begin
          if (frameo_n) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (cap && frameo_n) begin
            frame_err <= 1'b1;
          end else if (cap) begin
            shreg[0] <= dout;
            idx      <= 3'd1;
            state    <= RECV;
          end
        end
        RECV: begin
          if (cap) begin
            shreg[idx] <= dout;
            if (idx == 3'd7 || frameo_n) begin
              idx <= '0;
              if (frameo_n) begin
                state <= IDLE;
              end
              if (frameo_n && idx != 3'd7) begin
                frame_err <= 1'b1;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (frameo_n) begin
            frame_err <= 1'b1;
            idx       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= SKIP;
      endcase
    end
  end

  always_ff @(posedge SystemClk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  router_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (SystemClk),
    .reset     (reset),
    .push      (push),
    .push_data (push_e),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign rx.byte_valid = ~empty;
  assign rx.byte_data  = head.data;
  assign rx.byte_last  = head.last;
  assign busy          = (state == RECV) || (count != '0);

`ifdef RX_STATS_EN
  logic accepted;

  assign accepted = push & (~full | pop);

  always_ff @(posedge SystemClk) begin
    if (reset) begin
      pkt_cnt  <= '0;
      byte_cnt <= '0;
    end else if (accepted) begin
      byte_cnt <= byte_cnt + 1'b1;
      if (push_e.last) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_port_rx.sv
// Directed bench for router_port_rx: framing, gaps, errors,
// overflow, mid-packet reset and optional counters.
module tb_router_port_rx;

  logic clk = 1'b0;
  logic reset;
  logic dout;
  logic valido_n;
  logic frameo_n;
  logic frame_err;
  logic overflow;
  logic busy;
`ifdef RX_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] byte_cnt;
`endif

  int passed = 0;
  int total  = 0;
  int err_cyc = 0;
  int e0;
  logic [8:0] q[$];

  router_port_rx_if bus ();

  router_port_rx #(
    .FIFO_DEPTH (16)
  ) dut (
    .SystemClk (clk),
    .reset     (reset),
    .dout      (dout),
    .valido_n  (valido_n),
    .frameo_n  (frameo_n),
    .rx        (bus),
`ifdef RX_STATS_EN
    .pkt_cnt   (pkt_cnt),
    .byte_cnt  (byte_cnt),
`endif
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.byte_valid && bus.byte_ready)
      q.push_back({bus.byte_last, bus.byte_data});
    if (frame_err)
      err_cyc++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valido_n = 1'b1;
    frameo_n = 1'b1;
    dout     = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_pkt(input logic [31:0] d,
                          input int n,
                          input int gap_at,
                          input bit lat);
    for (int i = 0; i < n; i++) begin
      dout     = d[i];
      valido_n = 1'b0;
      frameo_n = (i == n - 1);
      tick();
      if (lat) chk("lat_valid", bus.byte_valid, (i % 8 == 7));
      if (i + 1 == gap_at) begin
        repeat (3) begin
          valido_n = 1'b1;
          frameo_n = 1'b0;
          tick();
          if (lat) chk("gap_valid", bus.byte_valid, 0);
        end
      end
    end
    idle(1);
  endtask

  initial begin
    reset = 1'b1;
    dout = 1'b0;
    valido_n = 1'b1;
    frameo_n = 1'b0;
    bus.byte_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", bus.byte_valid, 0);
    chk("rst_last", bus.byte_last, 0);
    chk("rst_data", bus.byte_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    idle(2);

    // two-byte packet, clean end
    q.delete();
    e0 = err_cyc;
    send_pkt(32'h3CA5, 16, 0, 0);
    idle(2);
    chk("p1_size", q.size(), 2);
    chk("p1_b0", q[0], 9'h0A5);
    chk("p1_b1", q[1], 9'h13C);
    chk("p1_ferr", err_cyc - e0, 0);

    // same packet with a 3-cycle gap after bit 5
    q.delete();
    e0 = err_cyc;
    send_pkt(32'h3CA5, 16, 5, 1);
    idle(2);
    chk("p2_size", q.size(), 2);
    chk("p2_b0", q[0], 9'h0A5);
    chk("p2_b1", q[1], 9'h13C);
    chk("p2_ferr", err_cyc - e0, 0);

    // 12-bit packet ends mid-byte
    q.delete();
    e0 = err_cyc;
    send_pkt(32'hFFF, 12, 0, 0);
    idle(2);
    chk("p3_size", q.size(), 2);
    chk("p3_b0", q[0], 9'h0FF);
    chk("p3_b1", q[1], 9'h10F);
    chk("p3_ferr", err_cyc - e0, 1);

    // overflow: 17 single-byte packets, consumer stalled
    q.delete();
    bus.byte_ready = 1'b0;
    for (int k = 0; k < 16; k++)
      send_pkt(32'(k + 1), 8, 0, 0);
    chk("ov_pre", overflow, 0);
    send_pkt(32'd17, 8, 0, 0);
    chk("ov_set", overflow, 1);
    chk("ov_busy", busy, 1);
    chk("ov_head", bus.byte_data, 8'd1);
    chk("ov_hlast", bus.byte_last, 1);
    bus.byte_ready = 1'b1;
    idle(20);
    chk("ov_size", q.size(), 16);
    for (int k = 0; k < 16; k++)
      chk("ov_byte", q[k], {1'b1, 8'(k + 1)});
    chk("ov_empty", bus.byte_valid, 0);
    chk("ov_sticky", overflow, 1);

    // reset mid-packet with a byte still buffered
    bus.byte_ready = 1'b0;
    send_pkt(32'h55, 8, 0, 0);
    chk("mr_buf", bus.byte_valid, 1);
    for (int k = 0; k < 3; k++) begin
      dout = k[0];
      valido_n = 1'b0;
      frameo_n = 1'b0;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_valid", bus.byte_valid, 0);
    chk("mr_data", bus.byte_data, 0);
    chk("mr_ovf", overflow, 0);
    chk("mr_busy", busy, 0);
    q.delete();
    e0 = err_cyc;
    for (int k = 0; k < 5; k++) begin
      dout = 1'b1;
      valido_n = 1'b0;
      frameo_n = (k == 4);
      tick();
    end
    chk("mr_skip", busy, 0);
    idle(2);
    bus.byte_ready = 1'b1;
    send_pkt(32'h81, 8, 0, 0);
    idle(2);
    chk("mr_size", q.size(), 1);
    chk("mr_byte", q[0], 9'h181);
    chk("mr_ferr", err_cyc - e0, 0);

`ifdef RX_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(2);
    send_pkt(32'h1234, 16, 0, 0);
    send_pkt(32'hBEEF, 16, 0, 0);
    send_pkt(32'h00C3, 16, 0, 0);
    idle(2);
    chk("st_pkt", pkt_cnt, 3);
    chk("st_byte", byte_cnt, 6);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
